// File: rtl/div_ctrl_pkg.sv
// Shared opcodes, state encoding and result layout for the EX-stage divide controller.
package div_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned RES_W  = 2 * DATA_W;

  localparam logic [OP_W-1:0]   EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [OP_W-1:0]   EXE_DIVU_OP = 8'b0001_1011;

  localparam logic              DIV_START   = 1'b1;
  localparam logic              DIV_STOP    = 1'b0;
  localparam logic [DATA_W-1:0] ZERO_WORD   = '0;

  typedef enum logic [1:0] {
    DivCtrlIdle = 2'b00,
    DivCtrlBusy = 2'b01,
    DivCtrlDone = 2'b10
  } div_ctrl_state_e;

  // Divider result word: remainder in the upper half, quotient in the lower half.
  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
  } div_result_t;

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage issue/collect controller for the iterative divider: freezes operands,
// drives start/annul, stalls the pipe until ready and presents the HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [DATA_W-1:0] div_opdata1_o,
  output logic [DATA_W-1:0] div_opdata2_o,
  input  logic [RES_W-1:0]  div_result_i,
  input  logic              div_ready_i,
  output logic              stallreq_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  div_ctrl_state_e   state_q, state_d;
  logic [DATA_W-1:0] op1_q, op2_q, hi_q, lo_q;
  logic              signed_q;
  logic              load_ops, load_res;
  div_result_t       result;

  assign result = div_result_t'(div_result_i);

  // Next state and handshake outputs; flush outranks ready (BUSY) and hold (DONE).
  always_comb begin
    state_d     = state_q;
    div_start_o = DIV_STOP;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    load_ops    = 1'b0;
    load_res    = 1'b0;
    case (state_q)
      DivCtrlIdle: begin
        if (is_div_op(aluop_i) && !flush_i) begin
          stallreq_o = 1'b1;
          load_ops   = 1'b1;
          state_d    = DivCtrlBusy;
        end
      end
      DivCtrlBusy: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = DivCtrlIdle;
        end else begin
          div_start_o = DIV_START;
          stallreq_o  = 1'b1;
          if (div_ready_i) begin
            load_res = 1'b1;
            state_d  = DivCtrlDone;
          end
        end
      end
      DivCtrlDone: begin
        if (flush_i) begin
          state_d = DivCtrlIdle;
        end else begin
          whilo_o = 1'b1;
          if (!ex_hold_i) state_d = DivCtrlIdle;
        end
      end
      default: state_d = DivCtrlIdle;
    endcase
  end

  // State, frozen operands and captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivCtrlIdle;
      op1_q    <= ZERO_WORD;
      op2_q    <= ZERO_WORD;
      signed_q <= 1'b0;
      hi_q     <= ZERO_WORD;
      lo_q     <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (load_ops) begin
        op1_q    <= reg1_i;
        op2_q    <= reg2_i;
        signed_q <= (aluop_i == EXE_DIV_OP);
      end
      if (load_res) begin
        hi_q <= result.rem;
        lo_q <= result.quo;
      end
    end
  end

  // Operands stay frozen for the whole divide since the divider re-reads signs at its end step.
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign div_signed_o  = signed_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural iterative divider attached.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam logic [7:0] NOP_OP = 8'h00;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2;
  logic        flush, ex_hold;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq, whilo;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  div_ctrl dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .flush_i(flush), .ex_hold_i(ex_hold),
    .div_start_o(div_start), .div_annul_o(div_annul), .div_signed_o(div_signed),
    .div_opdata1_o(div_op1), .div_opdata2_o(div_op2),
    .div_result_i(div_result), .div_ready_i(div_ready),
    .stallreq_o(stallreq), .whilo_o(whilo), .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural divider: ready in cycle 36 (cycle 4 for a zero divisor) counting the
  // cycle the controller first sees the DIV as cycle 0; result taken from operands at the end.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  int m_st, m_cnt, m_target;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0; m_cnt <= 0; m_target <= 0;
      div_ready <= 1'b0; div_result <= 64'd0;
    end else begin
      case (m_st)
        0: if (div_start && !div_annul) begin
             m_st <= 1; m_cnt <= 1;
             m_target <= (div_op2 == 32'd0) ? 4 : 36;
           end
        1: if (div_annul) m_st <= 0;
           else if (m_cnt == m_target - 2) begin
             m_st <= 2; div_ready <= 1'b1;
             div_result <= model_div(div_op1, div_op2, div_signed);
           end else m_cnt <= m_cnt + 1;
        default: if (!div_start) begin m_st <= 0; div_ready <= 1'b0; end
      endcase
    end
  end

  // Scoreboard monitor: one expected HI/LO pair per HI/LO write (first whilo cycle).
  logic whilo_prev = 1'b0;
  always @(negedge clk) begin
    if (rst && whilo && !whilo_prev) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL whilo_unexpected: got hi=0x%0h lo=0x%0h, required no write", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("hi_o", 64'(hi), 64'(e[63:32]));
        chk("lo_o", 64'(lo), 64'(e[31:0]));
      end
    end
    whilo_prev = rst ? whilo : 1'b0;
  end

  // Issue one divide at the current cycle (cycle 0) and follow it through DONE.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input int e_done, input int hold, input logic e_signed);
    int c = 0, done_c = -1, whilo_n = 0, stall_n = 0, start_in_done = 0, annul_n = 0;
    int hold_left = hold;
    bit finished = 0;
    aluop = op; reg1 = a; reg2 = b;
    exp_q.push_back({e_hi, e_lo});
    while (!finished && c < 200) begin
      @(negedge clk);
      if (c == 0) chk("stall_cycle0", 64'(stallreq), 64'd1);
      if (c == 1) begin
        chk("start_cycle1", 64'(div_start), 64'd1);
        chk("opdata1", 64'(div_op1), 64'(a));
        chk("opdata2", 64'(div_op2), 64'(b));
        chk("signed", 64'(div_signed), 64'(e_signed));
      end
      if (stallreq) stall_n++;
      if (div_annul) annul_n++;
      if (whilo) begin
        if (done_c < 0) done_c = c;
        whilo_n++;
        if (div_start) start_in_done++;
        if (hold_left > 0) begin ex_hold = 1'b1; hold_left--; end
        else begin ex_hold = 1'b0; finished = 1; end
      end
      @(posedge clk); #1;
      if (c == 0) begin reg1 = 32'hDEAD_BEEF; reg2 = 32'h1234_5678; end
      c++;
    end
    ex_hold = 1'b0; aluop = NOP_OP;
    chk("done_cycle", 64'(done_c), 64'(e_done));
    chk("whilo_cycles", 64'(whilo_n), 64'(hold + 1));
    chk("stall_cycles", 64'(stall_n), 64'(e_done));
    chk("restart_in_done", 64'(start_in_done), 64'd0);
    chk("annul_count", 64'(annul_n), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; aluop = NOP_OP; reg1 = '0; reg2 = '0; flush = 1'b0; ex_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 64'(div_start), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    chk("rst_whilo", 64'(whilo), 64'd0);
    chk("rst_hilo", 64'({hi, lo}), 64'd0);
    chk("rst_opdata", 64'({div_op1, div_op2}), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Unsigned, signed-looking unsigned, divide by zero
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 37, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 37, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    run_div(EXE_DIV_OP, 32'd5, 32'd0, 32'd0, 32'd0, 5, 0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Flush in cycle 10 of a divide
    begin
      int annul_n = 0, whilo_n = 0;
      aluop = EXE_DIVU_OP; reg1 = 32'd1000; reg2 = 32'd3;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_annul", 64'(div_annul), 64'd1);
      chk("flush_start", 64'(div_start), 64'd0);
      chk("flush_stall", 64'(stallreq), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; aluop = NOP_OP;
      repeat (45) begin
        @(negedge clk);
        if (div_annul) annul_n++;
        if (whilo) whilo_n++;
        @(posedge clk); #1;
      end
      chk("annul_after_flush", 64'(annul_n), 64'd0);
      chk("whilo_after_flush", 64'(whilo_n), 64'd0);
    end
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, 32'd0, 32'd3, 37, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Hold 3 cycles in DONE, then back-to-back DIV
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 3, 1'b1);
    run_div(EXE_DIV_OP, 32'd20, 32'd6, 32'd2, 32'd3, 37, 0, 1'b1);
    @(negedge clk);
    chk("hold_hi", 64'(hi), 64'd2);
    chk("hold_lo", 64'(lo), 64'd3);
    chk("idle_whilo", 64'(whilo), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset in BUSY
    aluop = EXE_DIV_OP; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (5) @(posedge clk);
    #2;
    chk("busy_before_rst", 64'(div_start), 64'd1);
    rst = 1'b0; aluop = NOP_OP;
    #1;
    chk("arst_start", 64'(div_start), 64'd0);
    chk("arst_stall", 64'(stallreq), 64'd0);
    chk("arst_opdata", 64'({div_op1, div_op2}), 64'd0);
    chk("arst_signed", 64'(div_signed), 64'd0);
    chk("arst_hilo", 64'({hi, lo}), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_start", 64'(div_start), 64'd0);
    @(posedge clk); #1;
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 37, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

EX-stage issue/collect controller sitting directly upstream of the `div` iterative divider. It decodes DIV/DIVU in EX, freezes the operands, and drives the divider's start/annul/signed handshake. It holds the pipeline stalled until the divider reports ready, then presents the 64-bit quotient/remainder as a HI/LO write to EX/MEM. It also cancels an in-flight divide on pipeline flush.

## Interface
Parameters: none. Opcodes and state encodings come from `defines.vh`.

- `clk` in 1: pipeline clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted 0).
- `aluop_i` in 8: EX-stage ALU op; `EXE_DIV_OP` is signed, `EXE_DIVU_OP` is unsigned.
- `reg1_i` in 32: dividend, `rs` value.
- `reg2_i` in 32: divisor, `rt` value.
- `flush_i` in 1: exception flush; kills the EX instruction.
- `ex_hold_i` in 1: downstream stall that holds the EX instruction in place.
- `div_start_o` out 1: divider `start_i`.
- `div_annul_o` out 1: divider `annul_i`.
- `div_signed_o` out 1: divider `signed_div_i`.
- `div_opdata1_o` out 32: divider dividend.
- `div_opdata2_o` out 32: divider divisor.
- `div_result_i` in 64: divider result, {remainder, quotient}.
- `div_ready_i` in 1: divider result ready.
- `stallreq_o` out 1: stall request to the pipeline controller.
- `whilo_o` out 1: HI/LO write enable to EX/MEM.
- `hi_o` out 32: HI write data (remainder).
- `lo_o` out 32: LO write data (quotient).

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - `is_div = (aluop_i==EXE_DIV_OP || aluop_i==EXE_DIVU_OP)`.
  - `stallreq_o = is_div && !flush_i` (combinational).
  - If `is_div && !flush_i`, then at the next edge:
    - latch `reg1_i` into `op1_q` and `reg2_i` into `op2_q`;
    - set `signed_q = (aluop_i==EXE_DIV_OP)`;
    - go to BUSY.
  - A flush or a non-div op leaves the FSM in IDLE.
- **BUSY:**
  - `div_start_o=1`, `stallreq_o=1`.
  - Operand outputs are driven from `op1_q`/`op2_q`/`signed_q` and stay stable for the whole operation, because the divider re-reads the operand signs at its end step.
  - `flush_i=1`: for one cycle `div_annul_o=1` and `div_start_o=0`, `stallreq_o=0`; next state IDLE; no HI/LO write.
  - `div_ready_i=1` (and no flush): latch `hi_q=div_result_i[63:32]` and `lo_q=div_result_i[31:0]`; next state DONE.
- **DONE:**
  - `div_start_o=0`, which releases the divider from its end state to free.
  - `stallreq_o=0`.
  - `whilo_o=1`, `hi_o=hi_q`, `lo_o=lo_q`.
  - Stay in DONE while `ex_hold_i=1`, without restarting; otherwise go to IDLE.
  - `flush_i=1` forces IDLE and drops `whilo_o` the same cycle.
- Outside DONE: `whilo_o=0`; `hi_o` and `lo_o` hold their last values.
- Flush has priority over ready in BUSY, and over hold in DONE.
- Divide-by-zero is not special-cased: the controller forwards the divider's result, which is all zeros.
- Back-to-back divides: a DIV arriving in the cycle after DONE is stalled in IDLE and issued normally. Since `start_o` is low in DONE, the divider has returned to free before the next start.

## Timing
- Reset (`rst=0`, asynchronous):
  - FSM goes to IDLE.
  - `op1_q`, `op2_q`, `signed_q`, `hi_q` and `lo_q` are cleared to 0.
  - All outputs are 0, except `stallreq_o`, which follows the combinational IDLE rule.
- Reset mid-operation abandons the divide; the divider must be reset by the same system reset.
- Let cycle 0 be the DIV in EX:
  - cycle 0: `stallreq_o=1`;
  - cycle 1: BUSY, start high;
  - the divider samples start at the end of cycle 1.
- Nominal latency (cycle in which `div_ready_i` is first seen; DONE follows one cycle later):

  | Case | Ready seen | DONE |
  |---|---|---|
  | Normal | cycle 36 | cycle 37 |
  | Divisor 0 | cycle 4 | cycle 5 |

- The controller waits on `div_ready_i` only and has no hard-coded count.
- The instruction advances at the end of the DONE cycle, when `ex_hold_i=0`.
- The annul pulse is exactly one cycle. It is issued only from BUSY, never combined with start.

## Structure
- Additions to `defines.vh`:
  - `EXE_DIV_OP` and `EXE_DIVU_OP`;
  - state encodings `DivCtrlIdle`, `DivCtrlBusy` and `DivCtrlDone` (2 bits);
  - reuse of the existing `DivStart`/`DivStop` and `ZEROWORD`.
- No sub-module. `div_ctrl` and `div` are peers, wired together in the EX stage.

## Test plan
- **Unsigned divide, real `div` attached.** DIVU 100 / 7. Required:
  - `stallreq_o` high cycles 0–36;
  - `whilo_o=1` for one cycle;
  - `lo_o=14`, `hi_o=2`.
- **Signed divide.** DIV 0xFFFFFFF9 (−7) / 2. Required:
  - `lo_o=0xFFFFFFFD`, `hi_o=0xFFFFFFFF`.
  - Also, DIVU 0xFFFFFFFF / 16 gives `lo_o=0x0FFFFFFF`, `hi_o=0xF`.
- **Divide by zero.** DIV 5 / 0. Required:
  - DONE in cycle 5;
  - `hi_o=lo_o=0`;
  - `whilo_o` pulses once.
- **Flush mid-divide.** `flush_i` at cycle 10. Required:
  - `div_annul_o` high for exactly cycle 10;
  - `stallreq_o=0`;
  - no `whilo_o`;
  - a following DIVU 9 / 3 returns `lo_o=3`, `hi_o=0`.
- **Hold, then back-to-back.** `ex_hold_i=1` for 3 cycles in DONE, followed by a back-to-back DIV 20 / 6. Required:
  - `whilo_o` held for 4 cycles, with no re-issue;
  - the second result is `lo_o=3`, `hi_o=2`.
- **Asynchronous reset during BUSY.** `rst` low mid-BUSY. Required:
  - outputs go to 0 immediately, without waiting for a clock edge;
  - the FSM is in IDLE after release.
